// File: rtl/matrix_row_gather.sv
// Gathers DIM0-wide row beats into DIM0xDIM1 matrices.
// Two ping-pong banks: one fills while the other drains.
module matrix_row_gather #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM0       = 4,
  parameter int DIM1       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DIM0-1:0][DATA_WIDTH-1:0]       in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [DIM0*DIM1-1:0][DATA_WIDTH-1:0]  out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int N  = DIM0 * DIM1;
  localparam int CW = (DIM1 > 1) ? $clog2(DIM1) : 1;

  logic [N-1:0][DATA_WIDTH-1:0] bank0;
  logic [N-1:0][DATA_WIDTH-1:0] bank1;
  logic [1:0]                   full;
  logic [1:0]                   full_nxt;
  logic                         wr_bank;
  logic                         rd_bank;
  logic [CW-1:0]                row_cnt;
  logic                         accept;
  logic                         take;
  logic                         last;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_data  = rd_bank ? bank1 : bank0;

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;
  assign last   = (row_cnt == CW'(DIM1 - 1));

  // Completion and drain always target different banks.
  always_comb begin
    full_nxt = full;
    if (accept && last) full_nxt[wr_bank] = 1'b1;
    if (take)           full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (accept) begin
      for (int r = 0; r < DIM1; r++) begin
        if (row_cnt == CW'(r)) begin
          if (wr_bank) bank1[r*DIM0 +: DIM0] <= in_data;
          else         bank0[r*DIM0 +: DIM0] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      row_cnt <= '0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        if (last) begin
          row_cnt <= '0;
          wr_bank <= !wr_bank;
        end else begin
          row_cnt <= row_cnt + 1'b1;
        end
      end
      if (take) rd_bank <= !rd_bank;
    end
  end

endmodule

// File: tb/tb_matrix_row_gather.sv
// Randomized bench for matrix_row_gather against a
// two-deep matrix queue model.
module tb_matrix_row_gather;

  localparam int DW   = 8;
  localparam int DIM0 = 4;
  localparam int DIM1 = 4;
  localparam int N    = DIM0 * DIM1;
  localparam int RW   = DIM0 * DW;
  localparam int MW   = N * DW;

  logic                  clk;
  logic                  rst;
  logic [DIM0-1:0][DW-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0][DW-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;

  int n_cmp;
  int n_bad;

  logic [MW-1:0] q[$];
  logic [MW-1:0] part;
  int            part_rows;
  int            rows_acc;
  int            mats_out;

  matrix_row_gather #(
    .DATA_WIDTH(DW), .DIM0(DIM0), .DIM1(DIM1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [MW-1:0] got,
                     input logic [MW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] v;
    for (int c = 0; c < DIM0; c++) v[c*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic model_clear();
    q.delete();
    part      = '0;
    part_rows = 0;
  endtask

  // Called #1 after an edge; checks, then advances one cycle.
  task automatic step(input logic v, input logic r,
                      input logic [RW-1:0] row);
    logic exp_rdy, exp_vld, acc, tk;
    in_valid  = v;
    out_ready = r;
    in_data   = row;
    exp_rdy   = (q.size() < 2);
    exp_vld   = (q.size() > 0);
    acc       = v && exp_rdy;
    tk        = r && exp_vld;
    #1;
    chk("in_ready", MW'(in_ready), MW'(exp_rdy));
    chk("out_valid", MW'(out_valid), MW'(exp_vld));
    if (exp_vld) chk("out_data", out_data, q[0]);
    @(posedge clk);
    #1;
    if (tk) begin
      void'(q.pop_front());
      mats_out++;
    end
    if (acc) begin
      part[part_rows*RW +: RW] = row;
      part_rows++;
      rows_acc++;
      if (part_rows == DIM1) begin
        q.push_back(part);
        part_rows = 0;
      end
    end
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk("rst_in_ready", MW'(in_ready), MW'(1'b1));
    chk("rst_out_valid", MW'(out_valid), MW'(1'b0));
    chk("rst_out_data", out_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [MW-1:0] ramp;
  logic [RW-1:0] rr;
  int            cyc;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rows_acc  = 0;
    mats_out  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", MW'(in_ready), MW'(1'b1));
    chk("reset_out_valid", MW'(out_valid), MW'(1'b0));
    chk("reset_out_data", out_data, '0);
    rst = 1'b0;

    // Single matrix with ramp contents.
    for (int i = 0; i < N; i++) ramp[i*DW +: DW] = DW'(i);
    for (int r = 0; r < DIM1; r++) step(1'b1, 1'b1, ramp[r*RW +: RW]);
    chk("single_valid", MW'(out_valid), MW'(1'b1));
    chk("single_data", out_data, ramp);
    step(1'b0, 1'b1, '0);
    chk("single_drained", MW'(out_valid), MW'(1'b0));

    // Back-to-back stream, no bubbles.
    for (int i = 0; i < 3*DIM1; i++) step(1'b1, 1'b1, rand_row());
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, '0);
    chk("b2b_out_count", MW'(mats_out), MW'(4));

    // Backpressure: fill both banks, stall row 9.
    for (int i = 0; i < 2*DIM1 + 2; i++) step(1'b1, 1'b0, rand_row());
    chk("bp_stalled", MW'(in_ready), MW'(1'b0));
    step(1'b1, 1'b1, rand_row());
    chk("bp_reopen", MW'(in_ready), MW'(1'b1));
    for (int i = 0; i < DIM1; i++) step(1'b1, 1'b0, rand_row());
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);

    // Simultaneous completion and drain.
    for (int i = 0; i < 2*DIM1 - 1; i++) step(1'b1, 1'b0, rand_row());
    rr = rand_row();
    step(1'b1, 1'b1, rr);
    chk("sim_valid", MW'(out_valid), MW'(1'b1));
    chk("sim_ready", MW'(in_ready), MW'(1'b1));
    chk("sim_last_row", MW'(out_data[N-DIM0 +: DIM0]), MW'(rr));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);

    // Bubbled random traffic over 100 matrices.
    rows_acc = 0;
    cyc      = 0;
    while (rows_acc < 100*DIM1 && cyc < 4000) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           rand_row());
      cyc++;
    end
    chk("rand_budget", MW'(rows_acc), MW'(100*DIM1));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);

    // Reset with one buffered matrix and two partial rows.
    for (int i = 0; i < DIM1 + 2; i++) step(1'b1, 1'b0, rand_row());
    async_reset();
    for (int i = 0; i < DIM1; i++) step(1'b1, 1'b0, rand_row());
    chk("post_rst_valid", MW'(out_valid), MW'(1'b1));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, '0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

endmodule
